// File: rtl/fetch_unit.sv
// fetch_unit: assembles a 32-bit big-endian instruction from four
// sequential byte reads on the flash read port.
module fetch_unit #(
  parameter int ADDR_W   = 24,
  parameter int READ_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  output logic              ready,
  output logic              instr_valid,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              fault,
  output logic              flash_re,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic [7:0]        flash_out
);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       instr_d;
  logic [ADDR_W-1:0] iaddr_d;
  logic              valid_d;
  logic              fault_d;
  logic              re_d;
  logic [ADDR_W-1:0] faddr_d;
  logic              capture;

  assign capture = (cnt_q == 4'(READ_LAT - 1));
  assign ready   = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    base_d  = base_q;
    instr_d = instruction;
    iaddr_d = instr_addr;
    valid_d = 1'b0;
    fault_d = 1'b0;
    re_d    = flash_re;
    faddr_d = flash_addr;
    unique case (state_q)
      IDLE: begin
        // flush wins over a coincident request
        if (fetch_req && !flush) begin
          if (fetch_addr[1:0] != 2'b00) begin
            fault_d = 1'b1;
          end else begin
            base_d  = fetch_addr;
            faddr_d = fetch_addr;
            re_d    = 1'b1;
            idx_d   = 2'd0;
            cnt_d   = 4'd0;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (flush) begin
          state_d = IDLE;
          re_d    = 1'b0;
        end else if (!capture) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = 4'd0;
          if (idx_q == 2'd3) begin
            instr_d = {asm_q, flash_out};
            iaddr_d = base_q;
            valid_d = 1'b1;
            re_d    = 1'b0;
            state_d = IDLE;
          end else begin
            asm_d   = {asm_q[15:0], flash_out};
            faddr_d = flash_addr + ADDR_W'(1);
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      base_q      <= '0;
      instruction <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      flash_re    <= 1'b0;
      flash_addr  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      base_q      <= base_d;
      instruction <= instr_d;
      instr_addr  <= iaddr_d;
      instr_valid <= valid_d;
      fault       <= fault_d;
      flash_re    <= re_d;
      flash_addr  <= faddr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized fetches against a flash
// model with 3-cycle read latency and a word-level reference model.
module tb_fetch_unit;

  localparam int L = 3;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic        flush;
  logic        ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [23:0] instr_addr;
  logic        fault;
  logic        flash_re;
  logic [23:0] flash_addr;
  logic [7:0]  flash_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  mem [logic [23:0]];
  logic [23:0] p0;
  logic [31:0] exp_instr;
  logic [23:0] exp_iaddr;

  fetch_unit #(.ADDR_W(24), .READ_LAT(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .flush      (flush),
    .ready      (ready),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .instr_addr (instr_addr),
    .fault      (fault),
    .flash_re   (flash_re),
    .flash_addr (flash_addr),
    .flash_out  (flash_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // two register stages: data valid before the third edge
  always @(posedge clk) begin
    p0        <= flash_addr;
    flash_out <= rd(p0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [23:0] a);
    logic [23:0] b;
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = a + 24'(k);
      w = {w[23:0], rd(b)};
    end
    return w;
  endfunction

  task automatic put_word(input logic [23:0] a, input logic [31:0] w);
    mem[a]         = w[31:24];
    mem[a + 24'd1] = w[23:16];
    mem[a + 24'd2] = w[15:8];
    mem[a + 24'd3] = w[7:0];
  endtask

  task automatic do_fetch(input logic [23:0] a);
    logic [31:0] e;
    logic [23:0] ea;
    e = word_at(a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    chk("acc_ready", 32'(ready), 0);
    chk("acc_fault", 32'(fault), 0);
    for (int i = 0; i < 4 * L; i++) begin
      ea = a + 24'(i / L);
      chk("rd_addr", 32'(flash_addr), 32'(ea));
      chk("rd_re", 32'(flash_re), 1);
      chk("rd_nvalid", 32'(instr_valid), 0);
      step();
    end
    chk("done_valid", 32'(instr_valid), 1);
    chk("done_instr", instruction, e);
    chk("done_iaddr", 32'(instr_addr), 32'(a));
    chk("done_re", 32'(flash_re), 0);
    chk("done_ready", 32'(ready), 1);
    exp_instr = e;
    exp_iaddr = a;
  endtask

  task automatic bad_fetch(input logic [23:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    chk("mis_fault", 32'(fault), 1);
    chk("mis_ready", 32'(ready), 1);
    chk("mis_re", 32'(flash_re), 0);
    chk("mis_instr", instruction, exp_instr);
    chk("mis_iaddr", 32'(instr_addr), 32'(exp_iaddr));
  endtask

  task automatic flush_fetch(input logic [23:0] a, input int n);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    repeat (n - 1) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_re", 32'(flash_re), 0);
    chk("fl_ready", 32'(ready), 1);
    chk("fl_valid", 32'(instr_valid), 0);
    chk("fl_instr", instruction, exp_instr);
    chk("fl_iaddr", 32'(instr_addr), 32'(exp_iaddr));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_quiet", 32'(instr_valid), 0);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_valid"}, 32'(instr_valid), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_instr"}, instruction, 0);
    chk({tag, "_iaddr"}, 32'(instr_addr), 0);
    chk({tag, "_re"}, 32'(flash_re), 0);
    chk({tag, "_faddr"}, 32'(flash_addr), 0);
  endtask

  initial begin
    int v1;
    int v2;
    int mode;
    logic [23:0] ra;
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    flush      = 1'b0;
    exp_instr  = '0;
    exp_iaddr  = '0;
    put_word(24'h000000, 32'h00A10093);
    put_word(24'h000004, 32'hDEADBEEF);
    put_word(24'hFFFFFC, 32'h12345678);
    #2 reset = 1'b0;
    #1 chk_reset_outs("rst");
    step();
    step();
    reset = 1'b1;
    step();
    chk_reset_outs("post_rst");

    do_fetch(24'h000000);
    chk("first_word", instruction, 32'h00A10093);
    v1 = cyc;
    do_fetch(24'h000004);
    v2 = cyc;
    chk("b2b_gap", 32'(v2 - v1), 13);
    chk("b2b_word", instruction, 32'hDEADBEEF);
    step();
    chk("valid_pulse", 32'(instr_valid), 0);

    bad_fetch(24'h000002);
    do_fetch(24'h000000);

    flush_fetch(24'h000004, 5);
    flush_fetch(24'h000004, 4 * L);

    flush      = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 24'h000004;
    step();
    flush     = 1'b0;
    fetch_req = 1'b0;
    chk("idle_fl_ready", 32'(ready), 1);
    chk("idle_fl_fault", 32'(fault), 0);
    chk("idle_fl_re", 32'(flash_re), 0);

    fetch_req  = 1'b1;
    fetch_addr = 24'h000004;
    step();
    fetch_req = 1'b0;
    repeat (2 * L) step();
    reset = 1'b0;
    #1 chk_reset_outs("mid_rst");
    #2 reset = 1'b1;
    exp_instr = '0;
    exp_iaddr = '0;
    step();
    do_fetch(24'h000000);
    chk("rst_refetch", instruction, 32'h00A10093);

    do_fetch(24'hFFFFFC);
    chk("top_word", instruction, 32'h12345678);
    chk("top_addr", 32'(flash_addr), 32'h00FFFFFF);

    for (int it = 0; it < 30; it++) begin
      mode = int'($urandom_range(0, 3));
      ra   = 24'($urandom) & 24'hFFFFFC;
      put_word(ra, $urandom);
      if (mode == 0) begin
        ra[1:0] = 2'($urandom_range(1, 3));
        bad_fetch(ra);
        step();
        chk("r_fault_pulse", 32'(fault), 0);
      end else if (mode == 1) begin
        flush_fetch(ra, int'($urandom_range(1, 4 * L)));
      end else begin
        do_fetch(ra);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
